// File: rtl/knn_axil_slave_regs.sv
// AXI4-Lite register bank for the KNN accelerator: four config regs, a status register, and the start/done handshake.
// Define KNN_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR.
module knn_axil_slave_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                      s00_axi_aclk,
    input  logic                      s00_axi_areset,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [4*DATA_WIDTH-1:0]   cfg_regs,
    output logic                      knn_start,
    input  logic                      knn_done
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = ADDR_WIDTH - 2;

    typedef enum logic {R_IDLE, R_VALID} rstate_t;

    logic clk;
    logic rst;
    assign clk = s00_axi_aclk;
    assign rst = s00_axi_areset;

    logic [3:0][DATA_WIDTH-1:0] cfg_q;
    logic                       done_q;

    logic                       aw_full;
    logic [IDX_W-1:0]           aw_idx;
    logic                       w_full;
    logic [DATA_WIDTH-1:0]      w_data;
    logic [STRB_W-1:0]          w_strb;

    logic aw_hs, w_hs, commit;
    logic aw_full_n, w_full_n, bvalid_n;
    logic wr_ok, wr_cfg, wr_stat, w1c_done;

    rstate_t               rstate;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_ok;

    logic unused;
    assign unused = ^{s_axi_awprot, s_axi_arprot,
                      s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign cfg_regs = cfg_q;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign commit = aw_full && w_full;

    assign wr_ok    = aw_idx <= IDX_W'(4);
    assign wr_cfg   = aw_idx <  IDX_W'(4);
    assign wr_stat  = aw_idx == IDX_W'(4);
    assign w1c_done = commit && wr_stat && w_strb[0] && w_data[0];

    // Next-state of the slots drives the registered ready outputs
    always_comb begin
        aw_full_n = aw_full | aw_hs;
        w_full_n  = w_full | w_hs;
        bvalid_n  = s_axi_bvalid & ~s_axi_bready;
        if (commit) begin
            aw_full_n = 1'b0;
            w_full_n  = 1'b0;
            bvalid_n  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full       <= 1'b0;
            aw_idx        <= '0;
            w_full        <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            cfg_q         <= '0;
            knn_start     <= 1'b0;
        end else begin
            knn_start     <= 1'b0;
            aw_full       <= aw_full_n;
            w_full        <= w_full_n;
            s_axi_bvalid  <= bvalid_n;
            s_axi_awready <= !aw_full_n && !bvalid_n;
            s_axi_wready  <= !w_full_n && !bvalid_n;
            if (aw_hs)
                aw_idx <= s_axi_awaddr[ADDR_WIDTH-1:2];
            if (w_hs) begin
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (commit) begin
`ifdef KNN_AXIL_SLVERR_EN
                s_axi_bresp <= wr_ok ? 2'b00 : 2'b10;
`else
                s_axi_bresp <= 2'b00;
`endif
                if (wr_cfg) begin
                    for (int b = 0; b < STRB_W; b++)
                        if (w_strb[b])
                            cfg_q[aw_idx[1:0]][8*b +: 8] <= w_data[8*b +: 8];
                end
                if (aw_idx == '0 && w_strb[0] && w_data[0])
                    knn_start <= 1'b1;
            end
        end
    end

    // Set has priority over the W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            done_q <= 1'b0;
        else if (knn_done)
            done_q <= 1'b1;
        else if (w1c_done)
            done_q <= 1'b0;
    end

    assign rd_idx = s_axi_araddr[ADDR_WIDTH-1:2];
    assign rd_ok  = rd_idx <= IDX_W'(4);

    always_comb begin
        rd_val = '0;
        if (rd_idx < IDX_W'(4))
            rd_val = cfg_q[rd_idx[1:0]];
        else if (rd_idx == IDX_W'(4))
            rd_val = {{(DATA_WIDTH-2){1'b0}}, knn_done, done_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate        <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= 2'b00;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_rdata   <= rd_val;
`ifdef KNN_AXIL_SLVERR_EN
                        s_axi_rresp   <= rd_ok ? 2'b00 : 2'b10;
`else
                        s_axi_rresp   <= 2'b00;
`endif
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        rstate        <= R_VALID;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_VALID: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    logic unused_rd;
    assign unused_rd = rd_ok;

endmodule

// File: tb/tb_knn_axil_slave_regs.sv
// Directed testbench for knn_axil_slave_regs.
// Exercises register R/W, strobes, handshake stalls, start/done and async reset.
module tb_knn_axil_slave_regs;

    logic         tb_ACLK = 1'b0;
    logic         tb_ARESET = 1'b1;
    logic [4:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [4:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [127:0] cfg_regs;
    logic         knn_start;
    logic         knn_done = 1'b0;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;

`ifdef KNN_AXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    knn_axil_slave_regs dut (
        .s00_axi_aclk   (tb_ACLK),
        .s00_axi_areset (tb_ARESET),
        .s_axi_awaddr   (awaddr),
        .s_axi_awprot   (awprot),
        .s_axi_awvalid  (awvalid),
        .s_axi_awready  (awready),
        .s_axi_wdata    (wdata),
        .s_axi_wstrb    (wstrb),
        .s_axi_wvalid   (wvalid),
        .s_axi_wready   (wready),
        .s_axi_bresp    (bresp),
        .s_axi_bvalid   (bvalid),
        .s_axi_bready   (bready),
        .s_axi_araddr   (araddr),
        .s_axi_arprot   (arprot),
        .s_axi_arvalid  (arvalid),
        .s_axi_arready  (arready),
        .s_axi_rdata    (rdata),
        .s_axi_rresp    (rresp),
        .s_axi_rvalid   (rvalid),
        .s_axi_rready   (rready),
        .cfg_regs       (cfg_regs),
        .knn_start      (knn_start),
        .knn_done       (knn_done)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    always @(negedge tb_ACLK)
        if (knn_start) start_cnt <= start_cnt + 1;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic axi_wr(input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp);
        bit aw_d = 0;
        bit w_d = 0;
        bit got = 0;
        bit aw_h, w_h;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20 && !(aw_d && w_d); i++) begin
            @(negedge tb_ACLK);
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            @(posedge tb_ACLK); #1;
            if (aw_h) begin awvalid = 1'b0; aw_d = 1; end
            if (w_h)  begin wvalid  = 1'b0; w_d  = 1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        resp = 2'bxx;
        bready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge tb_ACLK);
            if (bvalid) begin got = 1; resp = bresp; end
            @(posedge tb_ACLK); #1;
        end
        bready = 1'b0;
        chk("wr_handshake", {aw_d, w_d, got}, 3'b111);
    endtask

    task automatic axi_rd(input logic [4:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
        bit ar_d = 0;
        bit got = 0;
        bit ar_h;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20 && !ar_d; i++) begin
            @(negedge tb_ACLK);
            ar_h = arvalid && arready;
            @(posedge tb_ACLK); #1;
            if (ar_h) begin arvalid = 1'b0; ar_d = 1; end
        end
        arvalid = 1'b0;
        d = 'x; resp = 2'bxx;
        rready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge tb_ACLK);
            if (rvalid) begin got = 1; d = rdata; resp = rresp; end
            @(posedge tb_ACLK); #1;
        end
        rready = 1'b0;
        chk("rd_handshake", {ar_d, got}, 2'b11);
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        int          base;

        #3;
        chk("rst_outputs", {awready, wready, arready, bvalid, rvalid, knn_start},
            6'b0);
        chk("rst_resp_rdata", {bresp, rresp, rdata}, 36'h0);
        chk("rst_cfg", cfg_regs, 128'h0);
        @(negedge tb_ACLK);
        tb_ARESET = 1'b0;
        @(posedge tb_ACLK); #1;

        axi_wr(5'h00, 32'h0101FFFF, 4'hF, r); chk("bresp_r0", r, 2'b00);
        axi_wr(5'h04, 32'habcd0001, 4'hF, r); chk("bresp_r1", r, 2'b00);
        axi_wr(5'h08, 32'hdead0011, 4'hF, r); chk("bresp_r2", r, 2'b00);
        axi_wr(5'h0C, 32'hbeef0011, 4'hF, r); chk("bresp_r3", r, 2'b00);
        axi_rd(5'h00, d, r); chk("rd_r0", {r, d}, {2'b00, 32'h0101FFFF});
        axi_rd(5'h04, d, r); chk("rd_r1", {r, d}, {2'b00, 32'habcd0001});
        axi_rd(5'h08, d, r); chk("rd_r2", {r, d}, {2'b00, 32'hdead0011});
        axi_rd(5'h0C, d, r); chk("rd_r3", {r, d}, {2'b00, 32'hbeef0011});
        chk("cfg_all", cfg_regs,
            {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF});

        axi_wr(5'h04, 32'h12345678, 4'h5, r);
        axi_rd(5'h04, d, r); chk("strb_0x5", d, 32'hab340078);

        // W three cycles ahead of AW, bready held low
        bready = 1'b0;
        wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge tb_ACLK); chk("w_early_ready", wready, 1'b1);
        @(posedge tb_ACLK); #1; wvalid = 1'b0;
        @(negedge tb_ACLK); chk("wready_slot_full", wready, 1'b0);
        repeat (2) @(posedge tb_ACLK); #1;
        awaddr = 5'h08; awvalid = 1'b1;
        @(negedge tb_ACLK); chk("aw_late_ready", awready, 1'b1);
        @(posedge tb_ACLK); #1; awvalid = 1'b0;
        @(posedge tb_ACLK); #1;
        awaddr = 5'h0C; wdata = 32'hFFFFFFFF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_ACLK);
            chk("bvalid_hold", {bvalid, bresp, awready, wready}, 5'b1_00_0_0);
            @(posedge tb_ACLK); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge tb_ACLK); #1; bready = 1'b0;
        @(negedge tb_ACLK); chk("bvalid_cleared", bvalid, 1'b0);
        @(posedge tb_ACLK); #1;
        axi_rd(5'h08, d, r); chk("late_aw_commit", d, 32'h55AA55AA);
        axi_rd(5'h0C, d, r); chk("no_accept_while_b", d, 32'hbeef0011);

        base = start_cnt;
        axi_wr(5'h00, 32'h00000001, 4'hF, r);
        repeat (3) @(posedge tb_ACLK); #1;
        chk("start_one_cycle", start_cnt - base, 1);
        axi_rd(5'h00, d, r); chk("r0_no_selfclear", d, 32'h00000001);
        base = start_cnt;
        axi_wr(5'h04, 32'h00000001, 4'hF, r);
        repeat (3) @(posedge tb_ACLK); #1;
        chk("no_start_r1", start_cnt - base, 0);

        knn_done = 1'b1;
        @(posedge tb_ACLK); #1; knn_done = 1'b0;
        axi_rd(5'h10, d, r); chk("status_done", d, 32'h1);
        axi_wr(5'h10, 32'h1, 4'hF, r);
        axi_rd(5'h10, d, r); chk("status_w1c", d, 32'h0);
        knn_done = 1'b1;
        axi_wr(5'h10, 32'h1, 4'hF, r);
        axi_rd(5'h10, d, r); chk("status_set_wins", d, 32'h3);
        knn_done = 1'b0;
        @(posedge tb_ACLK); #1;
        axi_rd(5'h10, d, r); chk("status_sticky", d, 32'h1);

        axi_rd(5'h14, d, r); chk("oor_read", {r, d}, {OOR_RESP, 32'h0});
        axi_wr(5'h18, 32'hFFFFFFFF, 4'hF, r); chk("oor_bresp", r, OOR_RESP);
        chk("oor_no_change", cfg_regs,
            {32'hbeef0011, 32'h55AA55AA, 32'h00000001, 32'h00000001});

        // Async reset with both response channels pending
        awaddr = 5'h04; wdata = 32'h9; wstrb = 4'hF; araddr = 5'h00;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b0; rready = 1'b0;
        @(posedge tb_ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge tb_ACLK); #1;
        @(negedge tb_ACLK); chk("both_valid", {bvalid, rvalid}, 2'b11);
        #2 tb_ARESET = 1'b1;
        #1;
        chk("async_rst_valids", {bvalid, rvalid, awready, wready, arready},
            5'b0);
        chk("async_rst_cfg", cfg_regs, 128'h0);
        @(posedge tb_ACLK);
        @(negedge tb_ACLK); tb_ARESET = 1'b0;
        @(posedge tb_ACLK); #1;
        axi_rd(5'h00, d, r); chk("post_rst_r0", d, 32'h0);
        axi_rd(5'h0C, d, r); chk("post_rst_r3", d, 32'h0);
        axi_rd(5'h10, d, r); chk("post_rst_status", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/knn_axil_slave_regs.md
Name: knn_axil_slave_regs

Overview:
- AXI4-Lite responder (slave) register bank for the KNN accelerator S00_AXI port; answers the write/read bursts issued by the system's AXI4-Lite master.
- Holds four general R/W configuration registers (0x00-0x0C) and one status register (0x10).
- Generates a one-cycle start pulse to the KNN core and captures its sticky done flag.

Parameters:
- DATA_WIDTH, 32, AXI data width; fixed 32, byte strobes DATA_WIDTH/8.
- ADDR_WIDTH, 5, AXI address width; register index = addr[ADDR_WIDTH-1:2], addr[1:0] ignored.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_areset  in  1  reset; one clock, asynchronous, active-high
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- cfg_regs  out  128  {REG3,REG2,REG1,REG0}
- knn_start  out  1  one-cycle start pulse
- knn_done  in  1  level from core; sets sticky DONE

Behaviour:
- Reset (async assert, sync deassert use): all ready/valid outputs 0, bresp/rresp 00, rdata 0, REG0-3 0, DONE 0, knn_start 0.
- Register map:
  - 0x00-0x0C: REG0-3, R/W.
  - 0x10: STATUS, RO. Bit0 = DONE, bit1 = knn_done live, other bits 0. Writing 1 to bit0 clears DONE (W1C).
- Write channel:
  - AW and W are accepted independently into one-entry holding slots.
  - awready = 1 while the AW slot is empty and bvalid = 0; wready likewise for the W slot.
  - Commit happens the cycle after both slots are full. Each byte lane with wstrb = 1 is updated. Both slots are cleared and bvalid is set.
  - bvalid holds with bresp stable until bready. No new AW/W is accepted while bvalid = 1.
  - AW and W arriving in the same cycle commit one cycle later, so bvalid rises 2 cycles after the handshake.
- Start pulse: a committed write to REG0 with wstrb[0] = 1 and wdata[0] = 1 drives knn_start high for exactly one cycle, the cycle after the commit. The REG0 value still reads back as written (no self-clear).
- DONE: set on any cycle with knn_done = 1. A simultaneous W1C and knn_done leaves DONE = 1 (set wins).
- Read channel:
  - FSM R_IDLE/R_VALID.
  - arready = 1 in R_IDLE. On AR handshake, rdata is captured from current register values and state moves to R_VALID with rvalid = 1 the next cycle.
  - rdata/rresp are held until rready, then return to R_IDLE. Latency is 1 cycle.
- Simultaneous read and commit to the same register: the read returns the pre-write value.
- Out-of-range index (> 4): writes are ignored and reads return 0. Response is OKAY unless the optional feature is enabled.
- Read and write channels are fully concurrent.

Optional Feature:
- Macro KNN_AXIL_SLVERR_EN.
  - Defined: out-of-range accesses return bresp/rresp = 2'b10 (SLVERR), with rdata 0 and no register change.
  - Undefined: every access returns 2'b00 (OKAY).

Test Plan:
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x00/0x04/0x08/0x0C with strobe 0xF, then read each back -> identical data, all responses OKAY, cfg_regs = {0xbeef0011, 0xdead0011, 0xabcd0001, 0x0101FFFF}.
- REG1 = 0xabcd0001, then write 0x12345678 with wstrb = 0x5 -> readback 0xab340078.
- Present W 3 cycles before AW, with bready held low 5 cycles -> awready/wready stay low while bvalid is 1; exactly one commit; bvalid held stable until bready.
- Write 0x00000001 to 0x00 -> knn_start high exactly 1 cycle. Pulse knn_done -> STATUS reads 0x1. Write 0x1 to 0x10 -> STATUS reads 0x0. Repeat the W1C in the same cycle as knn_done -> STATUS reads 0x3 while knn_done is held high, 0x1 once it drops.
- Read 0x14 and write 0x18 -> rdata 0, no register change. Responses are OKAY without the macro and 2'b10 with KNN_AXIL_SLVERR_EN.
- Assert s00_axi_areset while bvalid = 1 and rvalid = 1 -> all valids drop immediately (asynchronous), registers read 0 after release.
